// File: rtl/sdram_wb_arbiter.sv
// rtl/sdram_wb_arbiter.sv - Wishbone arbiter sharing sdram_top between the core and the ioctl loader
//
// Purpose: grants the single SDRAM wishbone slave to either the Archimedes core
// master or the HPS ioctl loader. Loader writes are queued in a small FIFO and
// throttled with ld_wait_o. Core bursts are never split, and the core is held
// in reset until every loader write has reached SDRAM.
//
// Ports:
//   clk_sys, reset           system clock, asynchronous active-high reset
//   core_*_i / core_*_o      core wishbone master (word address, CTI bursts)
//   core_hold_o              core reset request while the loader is busy or draining
//   ld_*_i                   ioctl download strobe, byte address, data, byte selects
//   ld_wait_o                ioctl throttle, leaves room for one more write
//   ld_ovf_o                 sticky flag: a loader write hit a full FIFO and was dropped
//   ram_*_o / ram_*_i        wishbone master port towards sdram_top
module sdram_wb_arbiter #(
   parameter int ADDR_W     = 26,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              core_cyc_i,
   input  logic              core_stb_i,
   input  logic              core_we_i,
   input  logic [3:0]        core_sel_i,
   input  logic [2:0]        core_cti_i,
   input  logic [24:0]       core_adr_i,
   input  logic [31:0]       core_dat_i,
   output logic [31:0]       core_dat_o,
   output logic              core_ack_o,
   output logic              core_hold_o,
   input  logic              ld_active_i,
   input  logic              ld_wr_i,
   input  logic [24:0]       ld_addr_i,
   input  logic [31:0]       ld_data_i,
   input  logic [3:0]        ld_sel_i,
   output logic              ld_wait_o,
   output logic              ld_ovf_o,
   output logic              ram_cyc_o,
   output logic              ram_stb_o,
   output logic              ram_we_o,
   output logic [3:0]        ram_sel_o,
   output logic [2:0]        ram_cti_o,
   output logic [ADDR_W-1:0] ram_adr_o,
   output logic [31:0]       ram_dat_o,
   input  logic [31:0]       ram_dat_i,
   input  logic              ram_ack_i
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] WAIT_C  = CNT_W'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CORE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [24:0] fifo_addr [FIFO_DEPTH];
   logic [31:0] fifo_data [FIFO_DEPTH];
   logic [3:0]  fifo_sel  [FIFO_DEPTH];

   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count, count_next;
   logic              fifo_full, fifo_empty, push, pop;
   logic              core_req, core_last;
   logic [ADDR_W-1:0] head_ext, core_ext;

   assign fifo_full  = (count == DEPTH_C);
   assign fifo_empty = (count == '0);
   // A write arriving while full is dropped even if a pop happens in the same cycle.
   assign push       = ld_wr_i & ~fifo_full;
   assign pop        = (state == S_LOAD) & ram_ack_i;

   assign core_req   = core_cyc_i & core_stb_i & ~ld_active_i;
   assign core_last  = (core_cti_i == 3'b000) | (core_cti_i == 3'b111);

   assign head_ext   = ADDR_W'(fifo_addr[rd_ptr]);
   assign core_ext   = ADDR_W'({core_adr_i, 2'b00});

   assign core_dat_o = ram_dat_i;

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + CNT_W'(1);
      else if (!push && pop)
         count_next = count - CNT_W'(1);
   end

   // Storage needs no reset; only pointers and count carry validity.
   always_ff @(posedge clk_sys) begin
      if (push) begin
         fifo_addr[wr_ptr] <= ld_addr_i;
         fifo_data[wr_ptr] <= ld_data_i;
         fifo_sel[wr_ptr]  <= ld_sel_i;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         ld_wait_o   <= 1'b0;
         ld_ovf_o    <= 1'b0;
         core_hold_o <= 1'b1;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count     <= count_next;
         // Raised one entry early so the write already in flight still fits.
         ld_wait_o <= (count_next >= WAIT_C);
         if (ld_wr_i && fifo_full)
            ld_ovf_o <= 1'b1;
         // Built from next-cycle values so the hold drops right after the final loader ack.
         core_hold_o <= ld_active_i | (count_next != '0) | (state_next == S_LOAD);
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (!fifo_empty)
               state_next = S_LOAD;
            else if (core_req)
               state_next = S_CORE;
         end
         S_LOAD: begin
            if (ram_ack_i)
               state_next = S_IDLE;
         end
         S_CORE: begin
            // Only the core ends its own grant; a filling FIFO never breaks a burst.
            if (!core_cyc_i)
               state_next = S_IDLE;
            else if (ram_ack_i && core_last)
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      ram_cyc_o  = 1'b0;
      ram_stb_o  = 1'b0;
      ram_we_o   = 1'b0;
      ram_sel_o  = 4'b0000;
      ram_cti_o  = 3'b000;
      ram_adr_o  = '0;
      ram_dat_o  = 32'h0;
      core_ack_o = 1'b0;
      case (state)
         S_LOAD: begin
            ram_cyc_o = 1'b1;
            ram_stb_o = 1'b1;
            ram_we_o  = 1'b1;
            ram_sel_o = fifo_sel[rd_ptr];
            ram_adr_o = head_ext & ~ADDR_W'(3);
            ram_dat_o = fifo_data[rd_ptr];
         end
         S_CORE: begin
            ram_cyc_o  = core_cyc_i;
            ram_stb_o  = core_stb_i;
            ram_we_o   = core_we_i;
            ram_sel_o  = core_sel_i;
            ram_cti_o  = core_cti_i;
            ram_adr_o  = core_ext;
            ram_dat_o  = core_dat_i;
            core_ack_o = ram_ack_i;
         end
         default: begin
         end
      endcase
   end

endmodule
